dmem_access_unit: RTL
=====================

// Module: dmem_access_unit
// PURPOSE
//  Downstream of the pipeline core's MEM stage. Takes one data access per request
//  (address, store data, mem_w, DMType) and runs a req/ack handshake to word-wide
//  data RAM/IO. Builds byte enables and lane-shifted store data, and sign/zero-
//  extends load data. Returns rdata plus a one-cycle ready pulse (drives MIO_ready).
// PARAMETERS
//  AW          30   word-address width on memory side (byte addr bits [AW+1:2])
//  TIMEOUT     255  max cycles waiting for mem_ack before abort (8-bit counter)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   asynchronous, active-low reset
//  cpu_re       in   1   load request (sampled in IDLE only)
//  cpu_we       in   1   store request (sampled in IDLE; wins over cpu_re)
//  cpu_addr     in   32  byte address
//  cpu_wdata    in   32  store data, right-aligned
//  cpu_dmtype   in   3   000 W, 001 H, 010 HU, 011 B, 100 BU; others treated as W
//  cpu_rdata    out  32  extended load data, valid while cpu_ready=1
//  cpu_ready    out  1   1-cycle completion pulse (load or store)
//  busy         out  1   1 whenever state != IDLE (core stalls on it)
//  err          out  1   1-cycle pulse with cpu_ready on timeout/misalign abort
//  mem_req      out  1   held high from issue until mem_ack sampled
//  mem_we       out  1   write strobe, stable while mem_req=1
//  mem_addr     out  AW  word address = cpu_addr[AW+1:2]
//  mem_be       out  4   byte enables (loads: 4'b1111)
//  mem_wdata    out  32  lane-shifted store data
//  mem_ack      in   1   memory accepted (write) / rdata valid (read) this cycle
//  mem_rdata    in   32  raw word, sampled when mem_ack=1 and read
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, cpu_rdata=0, timeout counter=0.
//  States: IDLE -> REQ -> RESP -> IDLE; abort path REQ -> RESP with err.
//  IDLE: if cpu_we|cpu_re, capture addr/wdata/dmtype/we into regs, go REQ next
//   cycle; inputs need not stay stable afterwards. Else stay, outputs low.
//  REQ: mem_req=1, mem_* driven from captured regs; counter increments each cycle.
//   mem_ack=1 -> latch rdata (reads), go RESP. counter==TIMEOUT with no ack ->
//   drop mem_req, set err flag, go RESP. Ack in the same cycle as timeout: ack wins.
//  RESP: cpu_ready=1 for exactly one cycle, err=flag, then IDLE; counter cleared.
//  Latency: request in cycle 0, mem_req rises cycle 1; ack in cycle N -> cpu_ready
//   in cycle N+1. Zero-wait memory (ack in cycle 1) gives ready in cycle 2.
//  Back-to-back: a request present in the IDLE cycle after RESP is accepted;
//   requests during REQ/RESP are ignored (core holds via busy).
//  Byte lanes (o=addr[1:0]): B/BU be=4'b0001<<o, wdata={4{wdata[7:0]}};
//   H/HU be=o[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}}; W be=4'b1111.
//  Load extract: B/H sign-extend selected lane, BU/HU zero-extend, W passthrough.
//   Halfword lane picked by o[1] only; o[0] ignored unless trap enabled.
//  Timeout/abort: cpu_rdata=0, no write is ever issued for an aborted store's retry.
//  Reset mid-access: async clear to IDLE immediately, mem_req drops without ack.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined: in IDLE, H/HU with o[0]=1 or W with o!=0 skips REQ,
//   goes straight to RESP with err=1, cpu_rdata=0, no mem_req at all (ready cycle 1).
//  Undefined: no check; low address bits truncated per lane rules above.
// TESTING
//  Store W 0xDEADBEEF @0x100, ack after 2 wait cycles -> mem_addr=0x40, be=1111,
//   cpu_ready in cycle 4 (req cycles 1-3), busy high cycles 1-4.
//  Load B @0x103, mem_rdata=0x80FF_0000_ -> rdata: byte3=0x80 -> 0xFFFFFF80; BU -> 0x80.
//  Store H 0x1234 @0x0A -> be=1100, mem_wdata=0x12341234; load HU same word 0xABCD0000 -> 0xABCD.
//  No ack for 255 REQ cycles -> mem_req drops, cpu_ready+err pulse, cpu_rdata=0, back IDLE.
//  Assert rst low while in REQ -> all outputs 0 asynchronously, next request runs normally.
//  With DMEM_MISALIGN_TRAP_EN, load W @0x102 -> mem_req never asserts, err+ready cycle 1.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: req/ack handshake to word memory with byte-lane steering and load
// extension. Define DMEM_MISALIGN_TRAP_EN to abort misaligned H/HU/W accesses without a bus cycle.
module dmem_access_unit #(
    parameter int unsigned AW      = 30,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_re,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [2:0]    cpu_dmtype,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_ready,
    output logic          busy,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_t;

    localparam logic [2:0] DmH  = 3'b001;
    localparam logic [2:0] DmHu = 3'b010;
    localparam logic [2:0] DmB  = 3'b011;
    localparam logic [2:0] DmBu = 3'b100;
    // The counter holds the number of REQ cycles already spent, so abort on the last one.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  dmtype_q;
    logic [1:0]  off_q;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        misalign;

    assign busy = (state != StIdle);

    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = cpu_wdata;
        case (cpu_dmtype)
            DmB, DmBu: begin
                lane_be    = 4'b0001 << cpu_addr[1:0];
                lane_wdata = {4{cpu_wdata[7:0]}};
            end
            DmH, DmHu: begin
                lane_be    = cpu_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{cpu_wdata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        case (cpu_dmtype)
            DmB, DmBu: misalign = 1'b0;
            DmH, DmHu: misalign = cpu_addr[0];
            default:   misalign = |cpu_addr[1:0];
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (dmtype_q)
            DmB:     ld_data = {{24{ld_byte[7]}}, ld_byte};
            DmBu:    ld_data = {24'd0, ld_byte};
            DmH:     ld_data = {{16{ld_half[15]}}, ld_half};
            DmHu:    ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            cnt       <= 8'd0;
            dmtype_q  <= 3'd0;
            off_q     <= 2'd0;
            cpu_rdata <= 32'd0;
            cpu_ready <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            cpu_ready <= 1'b0;
            err       <= 1'b0;
            case (state)
                StIdle: begin
                    if (cpu_we || cpu_re) begin
                        dmtype_q <= cpu_dmtype;
                        off_q    <= cpu_addr[1:0];
                        if (misalign) begin
                            state     <= StResp;
                            cpu_ready <= 1'b1;
                            err       <= 1'b1;
                        end else begin
                            state     <= StReq;
                            mem_req   <= 1'b1;
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr[AW+1:2];
                            mem_be    <= cpu_we ? lane_be : 4'b1111;
                            mem_wdata <= cpu_we ? lane_wdata : 32'd0;
                        end
                    end
                end
                StReq: begin
                    if (mem_ack || (cnt == TimeoutLast)) begin
                        state     <= StResp;
                        cpu_ready <= 1'b1;
                        err       <= !mem_ack;
                        cpu_rdata <= (mem_ack && !mem_we) ? ld_data : 32'd0;
                        cnt       <= 8'd0;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= 4'd0;
                        mem_wdata <= 32'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StResp: begin
                    state     <= StIdle;
                    cnt       <= 8'd0;
                    cpu_rdata <= 32'd0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
